// File: rtl/ps2_key_tracker.sv
// PS/2 set-2 scan-code tracker: turns the receiver byte stream into a pressed-key bitmap
// plus a one-cycle event strobe, with prefix timeout and error recovery.
module ps2_key_tracker #(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter bit REPEAT_EN      = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   rx_byte,
  input  logic         rx_valid,
  input  logic         rx_err,
  output logic [127:0] key_down,
  output logic [8:0]   last_change,
  output logic         key_valid,
  output logic         overrun
);

  // state   | meaning
  // IDLE    | waiting for a make code or a prefix
  // BRK     | F0 seen, next byte is a released key
  // EXT     | E0 seen, extended keys are not tracked
  // EXT_BRK | E0 F0 seen, next byte is dropped
  // SKIP    | inside E1 pause sequence, skip_cnt bytes still to drop
  typedef enum logic [2:0] {IDLE, BRK, EXT, EXT_BRK, SKIP} state_t;

  localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  state_t        state;
  logic [TW-1:0] to_cnt;
  logic [2:0]    skip_cnt;
  logic [6:0]    code;

  assign code = rx_byte[6:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      to_cnt      <= '0;
      skip_cnt    <= '0;
      key_down    <= '0;
      last_change <= '0;
      key_valid   <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      overrun   <= 1'b0;
      if (rx_err) begin
        state    <= IDLE;
        skip_cnt <= '0;
        to_cnt   <= '0;
      end else if (rx_valid) begin
        to_cnt <= '0;
        case (state)
          IDLE: begin
            if (rx_byte == 8'hF0) begin
              state <= BRK;
            end else if (rx_byte == 8'hE0) begin
              state <= EXT;
            end else if (rx_byte == 8'hE1) begin
              state    <= SKIP;
              skip_cnt <= 3'd7;
            end else if (rx_byte == 8'h00 || rx_byte == 8'hFF) begin
              key_down <= '0;
              overrun  <= 1'b1;
            end else if (!rx_byte[7]) begin
              // bitmap and last_change move together so key_down[last_change] is coherent
              if (!key_down[code]) begin
                key_down[code] <= 1'b1;
                last_change    <= {2'b00, code};
                key_valid      <= 1'b1;
              end else if (REPEAT_EN) begin
                last_change <= {2'b00, code};
                key_valid   <= 1'b1;
              end
            end
          end
          BRK: begin
            state <= IDLE;
            if (!rx_byte[7] && key_down[code]) begin
              key_down[code] <= 1'b0;
              last_change    <= {2'b00, code};
              key_valid      <= 1'b1;
            end
          end
          EXT:     state <= (rx_byte == 8'hF0) ? EXT_BRK : IDLE;
          EXT_BRK: state <= IDLE;
          SKIP: begin
            skip_cnt <= skip_cnt - 3'd1;
            if (skip_cnt == 3'd1) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end else if (state != IDLE) begin
        // a byte arriving on the expiry cycle takes priority (branch above)
        if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
          state    <= IDLE;
          to_cnt   <= '0;
          skip_cnt <= '0;
        end else begin
          to_cnt <= to_cnt + TW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Bench for ps2_key_tracker: fixed vectors, corner sequences and random bytes checked
// against a sequence-queue reference model, with REPEAT_EN off and on.
module tb_ps2_key_tracker;
  localparam int T = 20;

  logic         clk, rst;
  logic [7:0]   rx_byte;
  logic         rx_valid, rx_err;
  logic [127:0] kd0, kd1;
  logic [8:0]   lc0, lc1;
  logic         kv0, kv1, ov0, ov1;

  int n_chk = 0;
  int n_fail = 0;

  ps2_key_tracker #(.TIMEOUT_CYCLES(T), .REPEAT_EN(1'b0)) dut0 (
    .clk(clk), .rst(rst), .rx_byte(rx_byte), .rx_valid(rx_valid), .rx_err(rx_err),
    .key_down(kd0), .last_change(lc0), .key_valid(kv0), .overrun(ov0));

  ps2_key_tracker #(.TIMEOUT_CYCLES(T), .REPEAT_EN(1'b1)) dut1 (
    .clk(clk), .rst(rst), .rx_byte(rx_byte), .rx_valid(rx_valid), .rx_err(rx_err),
    .key_down(kd1), .last_change(lc1), .key_valid(kv1), .overrun(ov1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: the partial multi-byte sequence is kept as a queue of bytes
  logic [7:0]   mseq[$];
  logic [127:0] m_down;
  logic [8:0]   m_last0, m_last1;
  logic         m_kv0, m_kv1, m_ovr;
  int           m_idle;

  task automatic model_reset();
    mseq.delete();
    m_down = '0; m_last0 = '0; m_last1 = '0;
    m_kv0 = 0; m_kv1 = 0; m_ovr = 0; m_idle = 0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    int k;
    k = int'(b);
    if (mseq.size() == 0) begin
      if (b == 8'hF0 || b == 8'hE0 || b == 8'hE1) mseq.push_back(b);
      else if (b == 8'h00 || b == 8'hFF) begin m_down = '0; m_ovr = 1; end
      else if (k < 128) begin
        if (!m_down[k]) begin
          m_down[k] = 1'b1; m_last0 = 9'(k); m_last1 = 9'(k); m_kv0 = 1; m_kv1 = 1;
        end else begin
          m_last1 = 9'(k); m_kv1 = 1;
        end
      end
    end else if (mseq[0] == 8'hF0) begin
      if (k < 128 && m_down[k]) begin
        m_down[k] = 1'b0; m_last0 = 9'(k); m_last1 = 9'(k); m_kv0 = 1; m_kv1 = 1;
      end
      mseq.delete();
    end else if (mseq[0] == 8'hE0) begin
      if (mseq.size() == 1 && b == 8'hF0) mseq.push_back(b);
      else mseq.delete();
    end else begin
      mseq.push_back(b);
      if (mseq.size() == 8) mseq.delete();
    end
  endtask

  task automatic model_step(input logic v, input logic e, input logic [7:0] b);
    m_kv0 = 0; m_kv1 = 0; m_ovr = 0;
    if (e) begin
      mseq.delete(); m_idle = 0;
    end else if (v) begin
      m_idle = 0;
      model_byte(b);
    end else if (mseq.size() > 0) begin
      m_idle++;
      if (m_idle >= T) begin mseq.delete(); m_idle = 0; end
    end
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic v, input logic e, input logic [7:0] b);
    @(negedge clk);
    rx_valid = v; rx_err = e; rx_byte = b;
    @(posedge clk);
    model_step(v, e, b);
    #1;
    chk("kv0", 128'(kv0), 128'(m_kv0));
    chk("kv1", 128'(kv1), 128'(m_kv1));
    chk("ovr0", 128'(ov0), 128'(m_ovr));
    chk("ovr1", 128'(ov1), 128'(m_ovr));
    chk("last0", 128'(lc0), 128'(m_last0));
    chk("last1", 128'(lc1), 128'(m_last1));
    chk("down0", kd0, m_down);
    chk("down1", kd1, m_down);
  endtask

  typedef struct {
    logic [7:0] b;
    logic       ekv;
    logic       eovr;
    logic [8:0] elast;
    int         bidx;
    logic       ebit;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(logic [7:0] b, logic ekv, logic eovr, logic [8:0] elast,
                              int bidx, logic ebit);
    vec_t v;
    v.b = b; v.ekv = ekv; v.eovr = eovr; v.elast = elast; v.bidx = bidx; v.ebit = ebit;
    tbl.push_back(v);
  endfunction

  initial begin
    int rep_pulses;
    int mode;
    int r;
    logic [7:0] b;
    logic [7:0] pal[6];

    add(8'h1C, 1, 0, 9'h01C, 'h1C, 1);
    add(8'hF0, 0, 0, 9'h01C, 'h1C, 1);
    add(8'h1C, 1, 0, 9'h01C, 'h1C, 0);
    add(8'h29, 1, 0, 9'h029, 'h29, 1);
    add(8'h29, 0, 0, 9'h029, 'h29, 1);
    add(8'h29, 0, 0, 9'h029, 'h29, 1);
    add(8'hE0, 0, 0, 9'h029, 'h75, 0);
    add(8'h75, 0, 0, 9'h029, 'h75, 0);
    add(8'hE0, 0, 0, 9'h029, 'h75, 0);
    add(8'hF0, 0, 0, 9'h029, 'h75, 0);
    add(8'h75, 0, 0, 9'h029, 'h75, 0);
    add(8'hE1, 0, 0, 9'h029, 'h14, 0);
    add(8'h14, 0, 0, 9'h029, 'h14, 0);
    add(8'h77, 0, 0, 9'h029, 'h77, 0);
    add(8'hE1, 0, 0, 9'h029, 'h14, 0);
    add(8'hF0, 0, 0, 9'h029, 'h14, 0);
    add(8'h14, 0, 0, 9'h029, 'h14, 0);
    add(8'hF0, 0, 0, 9'h029, 'h77, 0);
    add(8'h77, 0, 0, 9'h029, 'h77, 0);
    add(8'h66, 1, 0, 9'h066, 'h66, 1);
    add(8'h1C, 1, 0, 9'h01C, 'h1C, 1);
    add(8'h00, 0, 1, 9'h01C, 'h66, 0);

    rst = 1'b0; rx_valid = 1'b0; rx_err = 1'b0; rx_byte = 8'h00;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_down", kd0, '0);
    chk("rst_last", 128'(lc0), '0);
    chk("rst_kv", 128'(kv0), '0);
    chk("rst_ovr", 128'(ov0), '0);
    @(negedge clk); rst = 1'b1;

    rep_pulses = 0;
    foreach (tbl[i]) begin
      cyc(1'b1, 1'b0, tbl[i].b);
      chk($sformatf("tbl%0d_kv", i), 128'(kv0), 128'(tbl[i].ekv));
      chk($sformatf("tbl%0d_ovr", i), 128'(ov0), 128'(tbl[i].eovr));
      chk($sformatf("tbl%0d_last", i), 128'(lc0), 128'(tbl[i].elast));
      chk($sformatf("tbl%0d_bit", i), 128'(kd0[tbl[i].bidx]), 128'(tbl[i].ebit));
      if (i >= 3 && i <= 5) rep_pulses += int'(kv1);
    end
    chk("repeat_pulses", 128'(rep_pulses), 128'(3));
    chk("ovr_clear", kd0, '0);

    // F0 abandoned by timeout: the next 1C is a make
    cyc(1, 0, 8'hF0);
    repeat (T) cyc(0, 0, 8'h00);
    cyc(1, 0, 8'h1C);
    chk("timeout_kv", 128'(kv0), 128'(1));
    chk("timeout_bit", 128'(kd0[8'h1C]), 128'(1));

    // byte on the expiry cycle is still a break
    cyc(1, 0, 8'hF0);
    repeat (T - 1) cyc(0, 0, 8'h00);
    cyc(1, 0, 8'h1C);
    chk("expiry_brk_kv", 128'(kv0), 128'(1));
    chk("expiry_brk_bit", 128'(kd0[8'h1C]), 128'(0));

    // F0 abandoned by rx_err
    cyc(1, 0, 8'hF0);
    cyc(0, 1, 8'h00);
    cyc(1, 0, 8'h1C);
    chk("err_kv", 128'(kv0), 128'(1));
    chk("err_bit", 128'(kd0[8'h1C]), 128'(1));

    // error coincident with a byte drops the byte
    cyc(1, 1, 8'h29);
    chk("err_drop_kv", 128'(kv0), 128'(0));
    chk("err_drop_bit", 128'(kd0[8'h29]), 128'(0));

    // asynchronous reset while in BRK with 1C held
    cyc(1, 0, 8'hF0);
    @(negedge clk);
    rx_valid = 1'b0; rst = 1'b0;
    #1;
    model_reset();
    chk("arst_down", kd0, '0);
    chk("arst_last", 128'(lc0), '0);
    chk("arst_kv", 128'(kv0), '0);
    chk("arst_ovr", 128'(ov0), '0);
    @(negedge clk); rst = 1'b1;
    cyc(1, 0, 8'h1C);
    chk("arst_make_kv", 128'(kv0), 128'(1));
    chk("arst_make_bit", 128'(kd0[8'h1C]), 128'(1));

    pal[0] = 8'h1C; pal[1] = 8'h29; pal[2] = 8'h66;
    pal[3] = 8'h15; pal[4] = 8'h12; pal[5] = 8'h75;
    mode = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 150 == 0) mode = $urandom_range(0, 2);
      if ($urandom_range(0, 49) == 0) begin
        cyc(0, 1, 8'(($urandom_range(0, 255))));
      end else if ((mode == 0 && $urandom_range(0, 9) < 7) ||
                   (mode == 1 && $urandom_range(0, 19) == 0) ||
                   (mode == 2)) begin
        r = $urandom_range(0, 15);
        if (r <= 3 || r >= 10) b = pal[$urandom_range(0, 5)];
        else if (r <= 5) b = 8'hF0;
        else if (r == 6) b = 8'hE0;
        else if (r == 7) b = 8'hE1;
        else if (r == 8) b = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'hAA;
        else b = 8'($urandom_range(0, 255));
        cyc(1, 0, b);
      end else begin
        cyc(0, 0, 8'h00);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_key_tracker.md
# ps2_key_tracker

Converts the PS/2 scan-code byte stream into the key-state bus consumed by the typing-game counter (`key_down`, `last_change`, `key_valid`). It sits between the PS/2 byte receiver and the game/counter logic. It decodes set-2 make, break and extended prefixes, maintains a 128-bit pressed-key bitmap and suppresses typematic repeats. It also recovers from truncated sequences and overruns.

## Interface
- `TIMEOUT_CYCLES`, default 100000: idle cycles after a prefix byte before the partial sequence is discarded (1 ms at 100 MHz).
- `REPEAT_EN`, default 0: 1 = typematic repeat makes produce `key_valid`; 0 = suppressed.
- `clk`, in, 1: system clock, the only clock.
- `rst`, in, 1: asynchronous, active-low reset.
- `rx_byte`, in, 8: received scan-code byte.
- `rx_valid`, in, 1: one-cycle strobe; `rx_byte` is valid only while this is high.
- `rx_err`, in, 1: one-cycle strobe for a framing or parity error from the receiver.
- `key_down`, out, 128: bit k = 1 while non-extended code k is held.
- `last_change`, out, 9: code of the most recent reported event. Bit 8 is reserved and is always 0.
- `key_valid`, out, 1: one-cycle pulse; a new event is on `last_change` and `key_down`.
- `overrun`, out, 1: one-cycle pulse when a keyboard overrun code is received.

## Operation
States:
- IDLE
- BRK (F0 seen)
- EXT (E0 seen)
- EXT_BRK (E0 F0 seen)
- SKIP (inside E1 pause sequence, with a 3-bit remaining-byte counter)

IDLE, byte b on `rx_valid`:
- F0 → BRK.
- E0 → EXT.
- E1 → SKIP with counter = 7.
- 00 or FF → clear all `key_down`, pulse `overrun`, no `key_valid`.
- AA, FA, FE, EE → ignored; stay IDLE.
- b ≥ 0x80 (any other) → ignored.
- Otherwise (make of b):
  - If `key_down[b]` = 0: set it, `last_change` = {1'b0,b}, pulse `key_valid`.
  - If already 1: pulse `key_valid` only when `REPEAT_EN` = 1; `key_down` unchanged.

BRK, byte b:
- b < 0x80 and `key_down[b]` = 1: clear the bit, `last_change` = {1'b0,b}, pulse `key_valid`.
- b < 0x80 and bit already 0: no pulse.
- Either way → IDLE.
- b ≥ 0x80 → IDLE, dropped.

EXT:
- F0 → EXT_BRK.
- Any other byte → IDLE, dropped. Extended keys are not tracked.

EXT_BRK: any byte → IDLE, dropped.

SKIP: each byte decrements the counter. At 0 → IDLE. No outputs change.

Recovery:
- `rx_err` in any state → IDLE. The prefix or SKIP counter is discarded; `key_down` is kept.
- `rx_err` coincident with `rx_valid`: the error wins and the byte is dropped.
- Timeout counter: cleared on every `rx_valid`; counts while the state ≠ IDLE. When it reaches `TIMEOUT_CYCLES` → IDLE.
- `rx_valid` in the same cycle as timeout expiry: the byte is processed in the current state; the timeout is ignored.

`key_down` and `last_change` change only on a reported event, or on overrun (`key_down` only). `last_change` holds its value between events.

## Timing
- All outputs are registered.
- Byte with `rx_valid` at edge n → `key_down`, `last_change`, `key_valid` and `overrun` update at edge n+1.
- `key_valid` is high for exactly one cycle.
- Back-to-back `rx_valid` on consecutive cycles is supported; each byte is handled in its own cycle. Throughput is one byte per clock.
- Reset values: `key_down` = 0, `last_change` = 0, `key_valid` = 0, `overrun` = 0, state = IDLE, timeout counter = 0, SKIP counter = 0.
- Reset asserted mid-sequence: all of the above are cleared immediately, without waiting for a clock edge.
- The bitmap and `last_change` must be consistent in the same cycle as `key_valid`, because the consumer samples `key_down[last_change]`.

## Test plan
- Make then break: bytes 1C, F0 1C.
  - After 1C: `key_valid` pulses once, `last_change` = 0x01C, `key_down[0x1C]` = 1.
  - After F0 1C: another pulse, `key_down[0x1C]` = 0.
- Repeat suppression (`REPEAT_EN` = 0): bytes 29, 29, 29 → exactly one `key_valid`; `key_down[0x29]` = 1. With `REPEAT_EN` = 1, the same bytes give three pulses.
- Extended and pause sequences: bytes E0 75, E0 F0 75, then E1 14 77 E1 F0 14 F0 77, then 66.
  - No pulse during the extended and pause bytes.
  - The final 66 gives a pulse with `last_change` = 0x066.
- Overrun: hold 1C and 66, then byte 00 → `overrun` pulses, `key_down` = 0, no `key_valid`.
- Timeout and error recovery:
  - F0, then idle for `TIMEOUT_CYCLES` cycles, then 1C → treated as a make (pulse, bit set).
  - F0, then `rx_err`, then 1C → same result.
- Reset mid-sequence: with `key_down[0x1C]` = 1 and state BRK, pulse `rst` low → all outputs are 0 immediately. The following 1C is a make.
